recovery_rom_fetcher: RTL and testbench

Initiator side of the recovery code ROM read port. On a start pulse it streams a block of words out of the ROM (single-cycle synchronous read: data returned the cycle after a request) and delivers them one by one over a valid/ready instruction interface toward the core. A 2-entry buffer with in-flight accounting sustains one word per cycle under continuous ready and never drops a word under backpressure.

---
 rtl/recovery_rom_fetcher.sv | 144 ++++++++++++++
 tb/tb_recovery_rom_fetcher.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/recovery_rom_fetcher.sv
// Recovery ROM block fetcher: streams words from a synchronous ROM
// into a 2-entry FIFO and presents them on a valid/ready port.
module recovery_rom_fetcher #(
  parameter int CNT_W = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [31:0]      base_addr_i,
  input  logic [CNT_W-1:0] num_words_i,
  output logic             rom_req_o,
  output logic [31:0]      rom_addr_o,
  input  logic [31:0]      rom_rdata_i,
  output logic [31:0]      instr_o,
  output logic             instr_valid_o,
  input  logic             instr_ready_i,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             req_d;
  logic [31:0]      raddr_d;
  logic             rv_q, rv_d;
  logic             done_q, done_d;
  logic [31:0]      mem_q [DEPTH];
  logic             head_q, head_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             wr_idx;
  logic             pop, mpop, push;
  logic [2:0]       tot;
  logic             room_ok;
  logic [31:0]      base_al;

  assign base_al = base_addr_i & ~32'h3;

  // ROM data in its return cycle is bypassed to the head when empty
  assign instr_valid_o = (cnt_q != 2'd0) | rv_q;
  assign instr_o = (cnt_q == 2'd0 && rv_q) ? rom_rdata_i
                                           : mem_q[head_q];
  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;

  always_comb begin
    pop  = instr_valid_o & instr_ready_i;
    mpop = pop & (cnt_q != 2'd0);
    push = rv_q & ~((cnt_q == 2'd0) & pop);
    wr_idx = head_q + cnt_q[0];
    // stored + returning + requested words, after this cycle's pop
    tot = 3'(cnt_q) + 3'(rv_q) + 3'(rom_req_o);
    room_ok = (tot - 3'(pop)) < 3'(DEPTH);
    head_d = head_q ^ mpop;
    cnt_d  = cnt_q + 2'(push) - 2'(mpop);
    rv_d   = rom_req_o & ~abort_i;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    req_d   = 1'b0;
    raddr_d = rom_addr_o;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (num_words_i == '0) begin
            done_d = 1'b1;
          end else begin
            req_d   = 1'b1;
            raddr_d = base_al;
            addr_d  = base_al + 32'd4;
            rem_d   = num_words_i - CNT_W'(1);
            state_d = (num_words_i == CNT_W'(1))
                      ? DRAIN : FETCH;
          end
        end
      end
      FETCH: begin
        if (room_ok) begin
          req_d   = 1'b1;
          raddr_d = addr_q;
          addr_d  = addr_q + 32'd4;
          rem_d   = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && tot == 3'd1) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort_i) begin
      state_d = IDLE;
      req_d   = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      rom_req_o  <= 1'b0;
      rom_addr_o <= '0;
      rv_q       <= 1'b0;
      done_q     <= 1'b0;
      head_q     <= 1'b0;
      cnt_q      <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      rom_req_o  <= req_d;
      rom_addr_o <= raddr_d;
      rv_q       <= rv_d;
      done_q     <= done_d;
      if (abort_i) begin
        head_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        head_q <= head_d;
        cnt_q  <= cnt_d;
        if (push) mem_q[wr_idx] <= rom_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_recovery_rom_fetcher.sv
// Directed bench for recovery_rom_fetcher with a behavioural
// synchronous ROM returning 0xA0000000 + word index.
module tb_recovery_rom_fetcher;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        abort_i;
  logic [31:0] base_addr_i;
  logic [7:0]  num_words_i;
  logic        rom_req_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_rdata_i;
  logic [31:0] instr_o;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic        busy_o;
  logic        done_o;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] q_addr[$];
  int          q_rcyc[$];
  logic [31:0] q_word[$];
  int          done_cnt;
  int          done_cyc;
  logic        done_busy;
  logic        busy_seen;
  logic        stall_ok;

  typedef struct {
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] ins;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t tv[6];

  always #5 clk = ~clk;

  recovery_rom_fetcher #(.CNT_W(8), .DEPTH(2)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .base_addr_i  (base_addr_i),
    .num_words_i  (num_words_i),
    .rom_req_o    (rom_req_o),
    .rom_addr_o   (rom_addr_o),
    .rom_rdata_i  (rom_rdata_i),
    .instr_o      (instr_o),
    .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  function automatic logic [31:0] romw(input logic [31:0] a);
    return 32'hA000_0000 + {2'b00, a[31:2]};
  endfunction

  always_ff @(posedge clk) begin
    if (rst_i) rom_rdata_i <= '0;
    else if (rom_req_o) rom_rdata_i <= romw(rom_addr_o);
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [31:0] base,
                     input logic [7:0]  num,
                     input int lo_s,
                     input int lo_e,
                     input int rep);
    logic fin;
    q_addr.delete();
    q_rcyc.delete();
    q_word.delete();
    done_cnt  = 0;
    done_cyc  = -1;
    done_busy = 1'b0;
    busy_seen = 1'b0;
    stall_ok  = 1'b1;
    fin       = 1'b0;
    start_i       = 1'b1;
    base_addr_i   = base;
    num_words_i   = num;
    instr_ready_i = 1'b1;
    for (int c = 1; c <= 40 && !fin; c++) begin
      step();
      start_i       = (c == rep);
      base_addr_i   = (c == rep) ? 32'h800 : base;
      instr_ready_i = !(c >= lo_s && c <= lo_e);
      if (rom_req_o) begin
        q_addr.push_back(rom_addr_o);
        q_rcyc.push_back(c);
      end
      if (busy_o) busy_seen = 1'b1;
      if (c >= lo_s && c <= lo_e)
        if (!instr_valid_o || instr_o != romw(base))
          stall_ok = 1'b0;
      if (instr_valid_o && instr_ready_i)
        q_word.push_back(instr_o);
      if (done_o) begin
        done_cnt++;
        done_cyc  = c;
        done_busy = busy_o;
        fin       = 1'b1;
      end
    end
    chk("run_timeout", 32'(fin), 32'd1);
    instr_ready_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      if (done_o) done_cnt++;
      if (rom_req_o) q_addr.push_back(rom_addr_o);
    end
  endtask

  task automatic chk_q(input string nm,
                       input logic [31:0] got[$],
                       input logic [31:0] exp[$]);
    chk({nm, "_len"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk(nm, got[i], exp[i]);
  endtask

  initial begin
    logic [31:0] e[$];
    logic        bad;
    rst_i         = 1'b1;
    start_i       = 1'b0;
    abort_i       = 1'b0;
    base_addr_i   = '0;
    num_words_i   = '0;
    instr_ready_i = 1'b1;

    tv[0] = '{1, 1, 32'h0, 0, 32'h0,         1, 0};
    tv[1] = '{1, 1, 32'h4, 1, 32'hA000_0000, 1, 0};
    tv[2] = '{1, 1, 32'h8, 1, 32'hA000_0001, 1, 0};
    tv[3] = '{1, 0, 32'h8, 1, 32'hA000_0002, 1, 0};
    tv[4] = '{1, 0, 32'h8, 0, 32'h0,         0, 1};
    tv[5] = '{1, 0, 32'h8, 0, 32'h0,         0, 0};

    repeat (3) step();
    chk("rst_req",   32'(rom_req_o), 32'd0);
    chk("rst_addr",  rom_addr_o, 32'd0);
    chk("rst_instr", instr_o, 32'd0);
    chk("rst_valid", 32'(instr_valid_o), 32'd0);
    chk("rst_busy",  32'(busy_o), 32'd0);
    chk("rst_done",  32'(done_o), 32'd0);
    rst_i = 1'b0;
    step();

    // basic 3-word stream, table driven per cycle
    start_i     = 1'b1;
    base_addr_i = 32'h0;
    num_words_i = 8'd3;
    for (int c = 0; c < 6; c++) begin
      step();
      start_i       = 1'b0;
      instr_ready_i = tv[c].rdy;
      chk($sformatf("t1_req_c%0d", c + 1),
          32'(rom_req_o), 32'(tv[c].req));
      if (tv[c].req)
        chk($sformatf("t1_addr_c%0d", c + 1),
            rom_addr_o, tv[c].addr);
      chk($sformatf("t1_vld_c%0d", c + 1),
          32'(instr_valid_o), 32'(tv[c].vld));
      if (tv[c].vld)
        chk($sformatf("t1_ins_c%0d", c + 1),
            instr_o, tv[c].ins);
      chk($sformatf("t1_busy_c%0d", c + 1),
          32'(busy_o), 32'(tv[c].busy));
      chk($sformatf("t1_done_c%0d", c + 1),
          32'(done_o), 32'(tv[c].done));
    end

    // backpressure: ready low in cycles 2..6
    run(32'h10, 8'd4, 2, 6, -1);
    e = '{32'h10, 32'h14, 32'h18, 32'h1C};
    chk_q("t2_addr", q_addr, e);
    chk("t2_rc0", 32'(q_rcyc[0]), 32'd1);
    chk("t2_rc1", 32'(q_rcyc[1]), 32'd2);
    chk("t2_rc2", 32'(q_rcyc[2]), 32'd8);
    chk("t2_rc3", 32'(q_rcyc[3]), 32'd9);
    e = '{32'hA000_0004, 32'hA000_0005,
          32'hA000_0006, 32'hA000_0007};
    chk_q("t2_word", q_word, e);
    chk("t2_stall", 32'(stall_ok), 32'd1);
    chk("t2_dcnt", 32'(done_cnt), 32'd1);
    chk("t2_dcyc", 32'(done_cyc), 32'd11);

    // zero-length block
    run(32'h40, 8'd0, -1, -1, -1);
    chk("t3_nreq", 32'(q_addr.size()), 32'd0);
    chk("t3_dcyc", 32'(done_cyc), 32'd1);
    chk("t3_dcnt", 32'(done_cnt), 32'd1);
    chk("t3_busy", 32'(busy_seen), 32'd0);

    // address wrap
    run(32'hFFFF_FFFB, 8'd3, -1, -1, -1);
    e = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
    chk_q("t4_addr", q_addr, e);
    e = '{32'hDFFF_FFFE, 32'hDFFF_FFFF, 32'hA000_0000};
    chk_q("t4_word", q_word, e);
    chk("t4_dcyc", 32'(done_cyc), 32'd5);
    chk("t4_dbusy", 32'(done_busy), 32'd0);

    // abort in cycle 3 of an 8-word fetch
    start_i     = 1'b1;
    base_addr_i = 32'h100;
    num_words_i = 8'd8;
    step();
    start_i = 1'b0;
    step();
    step();
    abort_i = 1'b1;
    chk("t5_req_c3",  32'(rom_req_o), 32'd1);
    chk("t5_addr_c3", rom_addr_o, 32'h108);
    chk("t5_vld_c3",  32'(instr_valid_o), 32'd1);
    step();
    abort_i = 1'b0;
    chk("t5_req_c4",  32'(rom_req_o), 32'd0);
    chk("t5_vld_c4",  32'(instr_valid_o), 32'd0);
    chk("t5_busy_c4", 32'(busy_o), 32'd0);
    chk("t5_done_c4", 32'(done_o), 32'd0);
    bad = 1'b0;
    repeat (4) begin
      step();
      if (done_o || rom_req_o || instr_valid_o) bad = 1'b1;
    end
    chk("t5_quiet", 32'(bad), 32'd0);
    run(32'h200, 8'd2, -1, -1, -1);
    e = '{32'h200, 32'h204};
    chk_q("t5_addr", q_addr, e);
    e = '{32'hA000_0080, 32'hA000_0081};
    chk_q("t5_word", q_word, e);
    chk("t5_dcyc", 32'(done_cyc), 32'd4);

    // start pulsed while busy is ignored
    run(32'h300, 8'd3, -1, -1, 2);
    e = '{32'h300, 32'h304, 32'h308};
    chk_q("t6_addr", q_addr, e);
    e = '{32'hA000_00C0, 32'hA000_00C1, 32'hA000_00C2};
    chk_q("t6_word", q_word, e);
    chk("t6_dcnt", 32'(done_cnt), 32'd1);

    // start together with abort in IDLE
    start_i     = 1'b1;
    abort_i     = 1'b1;
    base_addr_i = 32'h900;
    num_words_i = 8'd5;
    step();
    start_i = 1'b0;
    abort_i = 1'b0;
    bad = 1'b0;
    repeat (5) begin
      if (rom_req_o || busy_o || instr_valid_o || done_o)
        bad = 1'b1;
      step();
    end
    chk("t6_sa_quiet", 32'(bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
